hc165_reader: RTL and testbench

- Serial input expander: drives a daisy-chain of 74HC165 parallel-in/serial-out shift registers and captures the chain contents into a parallel word.
- Companion to the 74HC595 output driver. That driver writes LEDs and segments; this block reads switches and keys through the same kind of 3-wire bus.
- Runs on the 50 MHz system clock. One capture is performed per start request, MSB first.

---
 rtl/hc165_reader_pkg.sv | 16 +
 rtl/hc165_reader_if.sv | 37 +++
 rtl/hc165_reader.sv | 130 +++++++++++++
 tb/tb_hc165_reader.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hc165_reader_pkg.sv
// Shared definitions for the 74HC165 serial input expander.
// Holds the FSM encoding and the defaults it shares with the 595 driver.
package hc165_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LOAD     = 2'd1,
    ST_SHIFT_LO = 2'd2,
    ST_SHIFT_HI = 2'd3
  } state_t;

  localparam int unsigned DEF_CNT_MAX = 2;
  localparam int unsigned DEF_WIDTH   = 16;
  localparam int unsigned DIV_W       = 8;

endpackage

// File: rtl/hc165_reader_if.sv
// Request/result and 3-wire bus signals of the 74HC165 reader.
// master = reader side, slave = requester plus chain side.
interface hc165_reader_if
  import hc165_reader_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
);

  logic             start;
  logic             q7;
  logic             sh_ld;
  logic             cp;
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             busy;

  modport master (
    input  start,
    input  q7,
    output sh_ld,
    output cp,
    output data,
    output valid,
    output busy
  );

  modport slave (
    output start,
    output q7,
    input  sh_ld,
    input  cp,
    input  data,
    input  valid,
    input  busy
  );

endinterface

// File: rtl/hc165_reader.sv
// Drives a 74HC165 daisy-chain and captures its contents MSB first.
// One capture per accepted start; all bus and result outputs registered.
module hc165_reader
  import hc165_reader_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned CNT_MAX = DEF_CNT_MAX
) (
  input  logic          clk,
  input  logic          reset_n,
  hc165_reader_if.master bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CNT_MAX - 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] w_div_nxt;
  logic [CNT_W-1:0] r_bit;
  logic [CNT_W-1:0] w_bit_nxt;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] w_shreg_nxt;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] w_data_nxt;
  logic             r_sh_ld;
  logic             w_sh_ld_nxt;
  logic             r_cp;
  logic             w_cp_nxt;
  logic             r_valid;
  logic             w_valid_nxt;
  logic             r_busy;
  logic             w_busy_nxt;
  logic             w_tick;

  assign w_tick = (r_div == DIV_LAST);

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_div   <= '0;
      r_bit   <= '0;
      r_shreg <= '0;
      r_data  <= '0;
      r_sh_ld <= 1'b1;
      r_cp    <= 1'b0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_div   <= w_div_nxt;
      r_bit   <= w_bit_nxt;
      r_shreg <= w_shreg_nxt;
      r_data  <= w_data_nxt;
      r_sh_ld <= w_sh_ld_nxt;
      r_cp    <= w_cp_nxt;
      r_valid <= w_valid_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  // Next-state and next-output logic; the divider free-runs outside IDLE
  always_comb begin
    w_state_nxt = r_state;
    w_div_nxt   = w_tick ? '0 : r_div + DIV_W'(1);
    w_bit_nxt   = r_bit;
    w_shreg_nxt = r_shreg;
    w_data_nxt  = r_data;
    w_sh_ld_nxt = r_sh_ld;
    w_cp_nxt    = r_cp;
    w_valid_nxt = 1'b0;
    w_busy_nxt  = r_busy;

    unique case (r_state)
      ST_IDLE: begin
        w_div_nxt   = '0;
        w_sh_ld_nxt = 1'b1;
        w_cp_nxt    = 1'b0;
        w_busy_nxt  = 1'b0;
        if (bus.start) begin
          w_state_nxt = ST_LOAD;
          w_sh_ld_nxt = 1'b0;
          w_busy_nxt  = 1'b1;
          w_bit_nxt   = '0;
        end
      end
      ST_LOAD: begin
        if (w_tick) begin
          w_state_nxt = ST_SHIFT_LO;
          w_sh_ld_nxt = 1'b1;
        end
      end
      ST_SHIFT_LO: begin
        // q7 settled at least CNT_MAX cycles after our own bus edge
        if (w_tick) begin
          w_shreg_nxt = {r_shreg[WIDTH-2:0], bus.q7};
          w_cp_nxt    = 1'b1;
          w_state_nxt = ST_SHIFT_HI;
        end
      end
      ST_SHIFT_HI: begin
        if (w_tick) begin
          w_cp_nxt = 1'b0;
          if (r_bit == BIT_LAST) begin
            w_state_nxt = ST_IDLE;
            w_data_nxt  = r_shreg;
            w_valid_nxt = 1'b1;
            w_busy_nxt  = 1'b0;
          end else begin
            w_bit_nxt   = r_bit + CNT_W'(1);
            w_state_nxt = ST_SHIFT_LO;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign bus.sh_ld = r_sh_ld;
  assign bus.cp    = r_cp;
  assign bus.data  = r_data;
  assign bus.valid = r_valid;
  assign bus.busy  = r_busy;

endmodule

// File: tb/tb_hc165_reader.sv
// Bench for hc165_reader: 74HC165 chain models feed q7, a scoreboard
// queue holds expected words and valid cycles, a monitor checks them.
module tb_hc165_reader;

  localparam int WA    = 16;
  localparam int CA    = 2;
  localparam int WB    = 8;
  localparam int CB    = 4;
  localparam int LAT_A = CA + 2 * CA * WA;
  localparam int LAT_B = CB + 2 * CB * WB;

  typedef struct {
    logic [63:0] data;
    int          cyc;
  } exp_t;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;
  int   cyc     = 0;
  int   total   = 0;
  int   bad     = 0;

  exp_t qa[$];
  exp_t qb[$];

  logic [WA-1:0] d_a     = '0;
  logic [WA-1:0] chain_a = '0;
  logic [WB-1:0] d_b     = '0;
  logic [WB-1:0] chain_b = '0;

  int   ld_a = 0, rise_a = 0, last_rise_a = 0;
  int   ld_b = 0, rise_b = 0, last_rise_b = 0;
  logic prev_cp_a = 1'b0, prev_cp_b = 1'b0;

  hc165_reader_if #(.WIDTH(WA)) bus_a ();
  hc165_reader_if #(.WIDTH(WB)) bus_b ();

  hc165_reader #(.WIDTH(WA), .CNT_MAX(CA)) dut_a (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_a)
  );

  hc165_reader #(.WIDTH(WB), .CNT_MAX(CB)) dut_b (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // 74HC165 chains: parallel load on SH/LD# low, shift toward Q7 on CP rise
  always @(posedge bus_a.cp or negedge bus_a.sh_ld)
    if (!bus_a.sh_ld) chain_a <= d_a;
    else              chain_a <= {chain_a[WA-2:0], 1'b0};
  assign bus_a.q7 = chain_a[WA-1];

  always @(posedge bus_b.cp or negedge bus_b.sh_ld)
    if (!bus_b.sh_ld) chain_b <= d_b;
    else              chain_b <= {chain_b[WB-2:0], 1'b0};
  assign bus_b.q7 = chain_b[WB-1];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Monitor for the 16-bit, CNT_MAX=2 reader
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        ld_a = 0; rise_a = 0; prev_cp_a = 1'b0;
      end else begin
        if (!bus_a.sh_ld) ld_a++;
        if (bus_a.cp && !prev_cp_a) begin
          rise_a++;
          if (rise_a > 1) check("cp_period_a", 64'(cyc - last_rise_a), 64'(2 * CA));
          last_rise_a = cyc;
        end
        prev_cp_a = bus_a.cp;
        if (bus_a.valid) begin
          if (qa.size() == 0) begin
            check("unexpected_valid_a", 64'(1), 64'(0));
          end else begin
            e = qa.pop_front();
            check("data_a", 64'(bus_a.data), e.data);
            check("valid_cycle_a", 64'(cyc), 64'(e.cyc));
            check("busy_at_valid_a", 64'(bus_a.busy), 64'(0));
            check("cp_rises_a", 64'(rise_a), 64'(WA));
            check("load_len_a", 64'(ld_a), 64'(CA));
          end
          ld_a = 0; rise_a = 0;
        end
      end
    end
  end

  // Monitor for the 8-bit, CNT_MAX=4 reader
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        ld_b = 0; rise_b = 0; prev_cp_b = 1'b0;
      end else begin
        if (!bus_b.sh_ld) ld_b++;
        if (bus_b.cp && !prev_cp_b) begin
          rise_b++;
          if (rise_b > 1) check("cp_period_b", 64'(cyc - last_rise_b), 64'(2 * CB));
          last_rise_b = cyc;
        end
        prev_cp_b = bus_b.cp;
        if (bus_b.valid) begin
          if (qb.size() == 0) begin
            check("unexpected_valid_b", 64'(1), 64'(0));
          end else begin
            e = qb.pop_front();
            check("data_b", 64'(bus_b.data), e.data);
            check("valid_cycle_b", 64'(cyc), 64'(e.cyc));
            check("busy_at_valid_b", 64'(bus_b.busy), 64'(0));
            check("cp_rises_b", 64'(rise_b), 64'(WB));
            check("load_len_b", 64'(ld_b), 64'(CB));
          end
          ld_b = 0; rise_b = 0;
        end
      end
    end
  end

  task automatic cap_a(input logic [WA-1:0] d, input int hold);
    d_a = d;
    @(negedge clk);
    bus_a.start = 1'b1;
    @(negedge clk);
    qa.push_back(exp_t'{data: 64'(d), cyc: cyc + LAT_A});
    repeat (hold - 1) @(negedge clk);
    bus_a.start = 1'b0;
  endtask

  task automatic cap_b(input logic [WB-1:0] d);
    d_b = d;
    @(negedge clk);
    bus_b.start = 1'b1;
    @(negedge clk);
    qb.push_back(exp_t'{data: 64'(d), cyc: cyc + LAT_B});
    bus_b.start = 1'b0;
  endtask

  task automatic drain_a(input int budget);
    int n = 0;
    while (qa.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (qa.size() != 0) begin
      check("timeout_a", 64'(qa.size()), 64'(0));
      qa.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic drain_b(input int budget);
    int n = 0;
    while (qb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (qb.size() != 0) begin
      check("timeout_b", 64'(qb.size()), 64'(0));
      qb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int a0;
    int n;
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;

    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_sh_ld_a", 64'(bus_a.sh_ld), 64'(1));
    check("rst_cp_a",    64'(bus_a.cp),    64'(0));
    check("rst_data_a",  64'(bus_a.data),  64'(0));
    check("rst_valid_a", 64'(bus_a.valid), 64'(0));
    check("rst_busy_a",  64'(bus_a.busy),  64'(0));
    check("rst_sh_ld_b", 64'(bus_b.sh_ld), 64'(1));
    check("rst_data_b",  64'(bus_b.data),  64'(0));
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    cap_b(8'h5A);
    drain_b(LAT_B + 20);

    cap_a(16'hA5C3, 1); drain_a(LAT_A + 20);
    cap_a(16'h0000, 1); drain_a(LAT_A + 20);
    cap_a(16'hFFFF, 1); drain_a(LAT_A + 20);
    cap_a(16'h8001, 1); drain_a(LAT_A + 20);

    // Re-pulses at +10 and +40 while busy must be ignored
    cap_a(16'h4321, 1);
    repeat (9) @(negedge clk);
    bus_a.start = 1'b1;
    @(negedge clk);
    bus_a.start = 1'b0;
    repeat (29) @(negedge clk);
    bus_a.start = 1'b1;
    @(negedge clk);
    bus_a.start = 1'b0;
    drain_a(LAT_A + 20);
    repeat (LAT_A + 10) @(negedge clk);
    cap_a(16'h1234, 1); drain_a(LAT_A + 20);

    // Reset after the 5th cp rise aborts the capture
    cap_a(16'hBEEF, 1);
    n = 0;
    while (rise_a < 5 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("rise5_reached", 64'(rise_a), 64'(5));
    check("busy_mid_capture", 64'(bus_a.busy), 64'(1));
    #2 reset_n = 1'b0;
    qa.delete();
    #1;
    check("abort_sh_ld", 64'(bus_a.sh_ld), 64'(1));
    check("abort_cp",    64'(bus_a.cp),    64'(0));
    check("abort_busy",  64'(bus_a.busy),  64'(0));
    check("abort_valid", 64'(bus_a.valid), 64'(0));
    check("abort_data",  64'(bus_a.data),  64'(0));
    @(negedge clk);
    reset_n = 1'b1;
    repeat (LAT_A + 20) @(negedge clk);
    cap_a(16'h6A6A, 1); drain_a(LAT_A + 20);

    // Randomized words, start pulse lengths and gaps
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      cap_a(WA'($urandom), int'($urandom_range(1, 8)));
      drain_a(LAT_A + 20);
    end

    // start held high: back-to-back captures every LAT_A+1 cycles
    d_a = 16'h00FF;
    @(negedge clk);
    bus_a.start = 1'b1;
    @(negedge clk);
    a0 = cyc;
    qa.push_back(exp_t'{data: 64'(16'h00FF), cyc: a0 + LAT_A});
    repeat (LAT_A) @(negedge clk);
    d_a = 16'hFF00;
    qa.push_back(exp_t'{data: 64'(16'hFF00), cyc: a0 + (LAT_A + 1) + LAT_A});
    repeat (LAT_A + 1) @(negedge clk);
    d_a = 16'h3C3C;
    qa.push_back(exp_t'{data: 64'(16'h3C3C), cyc: a0 + 2 * (LAT_A + 1) + LAT_A});
    repeat (LAT_A + 1) @(negedge clk);
    bus_a.start = 1'b0;
    drain_a(LAT_A + 20);
    repeat (LAT_A + 10) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
